mc_main_fsm: RTL and testbench
==============================

# mc_main_fsm

Main control state machine for the multicycle RV32I datapath. It decodes the instruction opcode over successive cycles and sequences the datapath mux selects and write enables. It drives `ALUOp` into `alu_decoder`, which sits directly downstream. It also adds a memory-ready stall on every memory access.

## Interface
Parameters:
- `STATE_W`, default 4: width of the state register and of the `State` debug output.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  opcode field from the instruction register.
- `Zero`  in  1  ALU zero flag, used by `beq`.
- `MemReady`  in  1  memory completes the current access this cycle.
- `ALUOp`  out  2  ALU operation class, sent to `alu_decoder`.
- `ALUSrcA`  out  2  ALU A-input select.
- `ALUSrcB`  out  2  ALU B-input select.
- `ResultSrc`  out  2  result-bus select.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `IRWrite`  out  1  instruction register load enable.
- `PCWrite`  out  1  PC load enable.
- `RegWrite`  out  1  register file write enable.
- `MemWrite`  out  1  data memory write enable.
- `IllegalOp`  out  1  one-cycle flag for an unsupported opcode.
- `State`  out  STATE_W  current state, for debug only.

## Operation
States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Encodings 11–15 are unreachable; if ever entered, the next state is FETCH.

Outputs are Moore outputs of the state. Any field not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=MemReady. PCUpdate=MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.

Derived outputs (combinational):
- PCWrite = PCUpdate | (Branch & Zero).

Transitions:
- FETCH→DECODE only when MemReady=1; otherwise remain in FETCH.
- DECODE, by `op`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → FETCH, with IllegalOp=1 for that DECODE cycle.
- MEMADR→MEMREAD if op=lw, otherwise →MEMWRITE.
- MEMREAD→MEMWB when MemReady=1; otherwise hold in MEMREAD.
- MEMWRITE→FETCH when MemReady=1; otherwise hold, with MemWrite held high.
- MEMWB, ALUWB and BEQ → FETCH.
- EXECUTER, EXECUTEI and JAL → ALUWB.

## Timing
- Reset: while `reset`=1, IRWrite, PCWrite, RegWrite, MemWrite and IllegalOp are forced to 0. At the first edge after reset the state is FETCH, and all other outputs take their FETCH values.
- Reset asserted mid-instruction: the state returns to FETCH on the next edge. No partial write may be issued in the reset cycle.
- Cycles per instruction with MemReady held at 1: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- Each low cycle of MemReady in FETCH, MEMREAD or MEMWRITE adds exactly one cycle to the instruction.
- `op` is sampled only in DECODE and MEMADR. The IR is stable in those states because IRWrite=0 there.
- `Zero` affects only PCWrite, and only in BEQ, within the same cycle. There is no registered effect.
- Registers are limited to the state register. All outputs are combinational from the state plus `MemReady`/`Zero`.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - mux-select constants.

  `alu_decoder` uses the same package.
- One sub-module is natural: `mc_ctrl_outputs`, a purely combinational state-to-control decoder. The top level keeps the state register and the next-state logic.

## Test plan
- Reset mid-MEMWRITE with MemReady=0 → next cycle State=0, MemWrite=0; with reset held high, all write enables read 0.
- lw (op=0000011) with MemReady=1 → State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4. ALUOp=00 throughout.
- R-type (0110011), then I-type (0010011) → states 0,1,6,7,0 and 0,1,8,7,0. ALUOp=10 in states 6 and 8.
- beq with Zero=1 → PCWrite=1 and ALUOp=01 in state 10. Repeat with Zero=0 → PCWrite=0. Both cases return to FETCH after 3 cycles.
- sw with MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, then State=0. A FETCH stall of 2 cycles → IRWrite=0 for 2 cycles, then 1.
- op=1111111 → DECODE asserts IllegalOp=1 for exactly 1 cycle, then State=0. No RegWrite or MemWrite is asserted.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multicycle RV32I controller and alu_decoder.
// Holds the main FSM state encoding, opcodes, ALUOp classes and datapath mux selects.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU A: current PC, PC of the instruction in IR, register operand
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_RESULT = 1'b1;

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational decoder from main FSM state to datapath control fields.
// Memory-facing strobes in FETCH follow MemReady so a stalled fetch does not load IR or PC.
module mc_ctrl_outputs
   import riscv_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic       i_memReady,
   output logic [1:0] o_aluOp,
   output logic [1:0] o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_resultSrc,
   output logic       o_adrSrc,
   output logic       o_irWrite,
   output logic       o_pcUpdate,
   output logic       o_branch,
   output logic       o_regWrite,
   output logic       o_memWrite
);

   always_comb begin
      o_aluOp     = ALUOP_ADD;
      o_aluSrcA   = SRCA_PC;
      o_aluSrcB   = SRCB_REG;
      o_resultSrc = RES_ALUOUT;
      o_adrSrc    = ADR_PC;
      o_irWrite   = 1'b0;
      o_pcUpdate  = 1'b0;
      o_branch    = 1'b0;
      o_regWrite  = 1'b0;
      o_memWrite  = 1'b0;
      case (i_state)
         S_FETCH: begin
            o_aluSrcB   = SRCB_FOUR;
            o_resultSrc = RES_ALURESULT;
            o_irWrite   = i_memReady;
            o_pcUpdate  = i_memReady;
         end
         S_DECODE: begin
            o_aluSrcA = SRCA_OLDPC;
            o_aluSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            o_aluSrcA = SRCA_REG;
            o_aluSrcB = SRCB_IMM;
         end
         S_MEMREAD: o_adrSrc = ADR_RESULT;
         S_MEMWB: begin
            o_resultSrc = RES_DATA;
            o_regWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            o_adrSrc   = ADR_RESULT;
            o_memWrite = 1'b1;
         end
         S_EXECUTER: begin
            o_aluSrcA = SRCA_REG;
            o_aluOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            o_aluSrcA = SRCA_REG;
            o_aluSrcB = SRCB_IMM;
            o_aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: o_regWrite = 1'b1;
         S_JAL: begin
            o_aluSrcA  = SRCA_OLDPC;
            o_aluSrcB  = SRCB_FOUR;
            o_pcUpdate = 1'b1;
         end
         S_BEQ: begin
            o_aluSrcA = SRCA_REG;
            o_aluOp   = ALUOP_SUB;
            o_branch  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle RV32I core: state register, next-state logic
// and reset gating of every write strobe so no partial write escapes a reset cycle.
module mc_main_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic               Zero,
   input  logic               MemReady,
   output logic [1:0]         ALUOp,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic               AdrSrc,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               IllegalOp,
   output logic [STATE_W-1:0] State
);

   state_t r_state;
   state_t w_nextState;
   logic   w_illegal;
   logic   w_irWrite;
   logic   w_pcUpdate;
   logic   w_branch;
   logic   w_regWrite;
   logic   w_memWrite;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_nextState;
   end

   // Memory states hold until MemReady; undefined encodings fall back to FETCH
   always_comb begin
      w_nextState = S_FETCH;
      w_illegal   = 1'b0;
      case (r_state)
         S_FETCH:    w_nextState = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_nextState = S_MEMADR;
               OP_R:         w_nextState = S_EXECUTER;
               OP_I:         w_nextState = S_EXECUTEI;
               OP_JAL:       w_nextState = S_JAL;
               OP_BEQ:       w_nextState = S_BEQ;
               default: begin
                  w_nextState = S_FETCH;
                  w_illegal   = 1'b1;
               end
            endcase
         end
         S_MEMADR:   w_nextState = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_nextState = MemReady ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: w_nextState = MemReady ? S_FETCH : S_MEMWRITE;
         S_EXECUTER, S_EXECUTEI, S_JAL: w_nextState = S_ALUWB;
         default:    w_nextState = S_FETCH;
      endcase
   end

   mc_ctrl_outputs uOutputs (
      .i_state     (r_state),
      .i_memReady  (MemReady),
      .o_aluOp     (ALUOp),
      .o_aluSrcA   (ALUSrcA),
      .o_aluSrcB   (ALUSrcB),
      .o_resultSrc (ResultSrc),
      .o_adrSrc    (AdrSrc),
      .o_irWrite   (w_irWrite),
      .o_pcUpdate  (w_pcUpdate),
      .o_branch    (w_branch),
      .o_regWrite  (w_regWrite),
      .o_memWrite  (w_memWrite)
   );

   assign IRWrite   = w_irWrite & ~reset;
   assign PCWrite   = (w_pcUpdate | (w_branch & Zero)) & ~reset;
   assign RegWrite  = w_regWrite & ~reset;
   assign MemWrite  = w_memWrite & ~reset;
   assign IllegalOp = w_illegal & ~reset;
   assign State     = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm: table of per-cycle vectors fed through a
// scoreboard queue, followed by cycles-per-instruction measurements.
module tb_mc_main_fsm;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       Zero;
   logic       MemReady;
   logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;

   // Write-enable field order: {IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp}
   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic       zero;
      logic       memReady;
      logic [3:0] expState;
      logic [1:0] expAluOp;
      logic [4:0] expWe;
   } vec_t;

   vec_t vecs[$];
   vec_t sbQ[$];
   int   tagQ[$];

   mc_main_fsm #(.STATE_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .Zero      (Zero),
      .MemReady  (MemReady),
      .ALUOp     (ALUOp),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ResultSrc (ResultSrc),
      .AdrSrc    (AdrSrc),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .IllegalOp (IllegalOp),
      .State     (State)
   );

   always #5 clk = ~clk;

   // Mux selects per state as {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}
   function automatic logic [6:0] expMux(input logic [3:0] s);
      case (s)
         4'd0:    return {2'b00, 2'b10, 2'b10, 1'b0};
         4'd1:    return {2'b01, 2'b01, 2'b00, 1'b0};
         4'd2:    return {2'b10, 2'b01, 2'b00, 1'b0};
         4'd3:    return {2'b00, 2'b00, 2'b00, 1'b1};
         4'd4:    return {2'b00, 2'b00, 2'b01, 1'b0};
         4'd5:    return {2'b00, 2'b00, 2'b00, 1'b1};
         4'd6:    return {2'b10, 2'b00, 2'b00, 1'b0};
         4'd8:    return {2'b10, 2'b01, 2'b00, 1'b0};
         4'd9:    return {2'b01, 2'b10, 2'b00, 1'b0};
         4'd10:   return {2'b10, 2'b00, 2'b00, 1'b0};
         default: return 7'b0;
      endcase
   endfunction

   function automatic vec_t mk(input logic rst, input logic [6:0] o, input logic z,
                               input logic mr, input logic [3:0] s, input logic [1:0] a,
                               input logic [4:0] we);
      vec_t v;
      v.rst = rst; v.op = o; v.zero = z; v.memReady = mr;
      v.expState = s; v.expAluOp = a; v.expWe = we;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      @(posedge clk);
      #1;
      reset    = v.rst;
      op       = v.op;
      Zero     = v.zero;
      MemReady = v.memReady;
      sbQ.push_back(v);
      tagQ.push_back(idx);
   endtask

   task automatic checkOutput();
      vec_t e;
      int   idx;
      @(negedge clk);
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue expected one entry");
         return;
      end
      e   = sbQ.pop_front();
      idx = tagQ.pop_front();
      cmp("State", idx, 8'(State), 8'(e.expState));
      cmp("ALUOp", idx, 8'(ALUOp), 8'(e.expAluOp));
      cmp("WriteEnables", idx, 8'({IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp}), 8'(e.expWe));
      cmp("MuxSel", idx, 8'({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}), 8'(expMux(e.expState)));
   endtask

   task automatic measureCpi(input string name, input logic [6:0] o, input int expCycles);
      int cycles;
      @(posedge clk); #1;
      reset = 1'b1; op = o; Zero = 1'b0; MemReady = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      cmp({name, "_start"}, -1, 8'(State), 8'd0);
      cycles = 1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (State == 4'd0) break;
         cycles++;
      end
      cmp({name, "_cpi"}, -1, 8'(cycles), 8'(expCycles));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; op = 7'd0; Zero = 1'b0; MemReady = 1'b0;
      repeat (2) @(posedge clk);

      // reset held in FETCH, then lw with no stalls
      vecs.push_back(mk(1, LW, 0, 1, 4'd0, 2'b00, 5'b00000));
      vecs.push_back(mk(0, LW, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, LW, 0, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, LW, 0, 1, 4'd2, 2'b00, 5'b00000));
      vecs.push_back(mk(0, LW, 0, 1, 4'd3, 2'b00, 5'b00000));
      vecs.push_back(mk(0, LW, 0, 1, 4'd4, 2'b00, 5'b00100));
      // R-type then I-type
      vecs.push_back(mk(0, RT, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, RT, 0, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, RT, 0, 1, 4'd6, 2'b10, 5'b00000));
      vecs.push_back(mk(0, RT, 0, 1, 4'd7, 2'b00, 5'b00100));
      vecs.push_back(mk(0, IT, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, IT, 0, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, IT, 0, 1, 4'd8, 2'b10, 5'b00000));
      vecs.push_back(mk(0, IT, 0, 1, 4'd7, 2'b00, 5'b00100));
      // beq taken, then not taken; Zero outside BEQ must not move the PC
      vecs.push_back(mk(0, BQ, 1, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, BQ, 1, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, BQ, 1, 1, 4'd10, 2'b01, 5'b01000));
      vecs.push_back(mk(0, BQ, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, BQ, 0, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, BQ, 0, 1, 4'd10, 2'b01, 5'b00000));
      // jal
      vecs.push_back(mk(0, JL, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, JL, 0, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, JL, 0, 1, 4'd9, 2'b00, 5'b01000));
      vecs.push_back(mk(0, JL, 0, 1, 4'd7, 2'b00, 5'b00100));
      // sw with three stalled MEMWRITE cycles
      vecs.push_back(mk(0, SW, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, SW, 0, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, SW, 0, 1, 4'd2, 2'b00, 5'b00000));
      vecs.push_back(mk(0, SW, 0, 0, 4'd5, 2'b00, 5'b00010));
      vecs.push_back(mk(0, SW, 0, 0, 4'd5, 2'b00, 5'b00010));
      vecs.push_back(mk(0, SW, 0, 0, 4'd5, 2'b00, 5'b00010));
      vecs.push_back(mk(0, SW, 0, 1, 4'd5, 2'b00, 5'b00010));
      // two-cycle fetch stall, then an illegal opcode
      vecs.push_back(mk(0, BAD, 0, 0, 4'd0, 2'b00, 5'b00000));
      vecs.push_back(mk(0, BAD, 0, 0, 4'd0, 2'b00, 5'b00000));
      vecs.push_back(mk(0, BAD, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, BAD, 0, 1, 4'd1, 2'b00, 5'b00001));
      // lw with a MEMREAD stall and reset during MEMWB
      vecs.push_back(mk(0, LW, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, LW, 0, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, LW, 0, 1, 4'd2, 2'b00, 5'b00000));
      vecs.push_back(mk(0, LW, 0, 0, 4'd3, 2'b00, 5'b00000));
      vecs.push_back(mk(0, LW, 0, 1, 4'd3, 2'b00, 5'b00000));
      vecs.push_back(mk(1, LW, 0, 1, 4'd4, 2'b00, 5'b00000));
      // reset mid-MEMWRITE while memory is stalled
      vecs.push_back(mk(0, SW, 0, 1, 4'd0, 2'b00, 5'b11000));
      vecs.push_back(mk(0, SW, 0, 1, 4'd1, 2'b00, 5'b00000));
      vecs.push_back(mk(0, SW, 0, 1, 4'd2, 2'b00, 5'b00000));
      vecs.push_back(mk(0, SW, 0, 0, 4'd5, 2'b00, 5'b00010));
      vecs.push_back(mk(1, SW, 0, 0, 4'd5, 2'b00, 5'b00000));
      vecs.push_back(mk(1, SW, 0, 1, 4'd0, 2'b00, 5'b00000));
      vecs.push_back(mk(0, SW, 0, 1, 4'd0, 2'b00, 5'b11000));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], i);
         checkOutput();
      end

      measureCpi("lw", LW, 5);
      measureCpi("sw", SW, 4);
      measureCpi("rtype", RT, 4);
      measureCpi("itype", IT, 4);
      measureCpi("jal", JL, 4);
      measureCpi("beq", BQ, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
